apb_arb_master: RTL and testbench

APB_ARB_MASTER -- requirements
Module: apb_arb_master

---
 rtl/apb_arb_master.sv | 164 ++++++++++++++++
 tb/tb_apb_arb_master.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_arb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_master
// Description : Two-requester APB master. A round-robin arbiter picks one
//               requester, latches its operands and runs a single APB
//               transfer (SETUP then ACCESS) to one of two slaves, which are
//               selected by address bits [31:28]. An ACCESS phase that waits
//               too long for pready is aborted with an error.
// Ports       : clk, rst_n (synchronous, active-low)
//               req0/1, wr0/1, addr0/1, wdata0/1 : requester side inputs
//               gnt0/1, done0/1, rdata, err      : requester side outputs
//               psel, penable, pwrite, paddr, pwdata : APB request outputs
//               prdata, pready, pslverr          : APB slave response
// Revision    : 1.0 - initial release
// ============================================================================
module apb_arb_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        err,
  output logic [1:0]  psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam int            c_cnt_w     = $clog2(TIMEOUT + 1);
  // Last wait count before abort: the edge that would make the counter
  // reach TIMEOUT is the edge that aborts.
  localparam logic [c_cnt_w-1:0] c_wait_last = c_cnt_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_lp;       // last-served requester
  logic               r_owner;    // requester owning the current transfer
  logic               r_dec_err;  // current transfer hit no slave
  logic [c_cnt_w-1:0] r_wait;

  logic        w_pick;
  logic        w_wr;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [1:0]  w_dec;

  // Arbitration and decode of the candidate transfer, used only in IDLE.
  // On a conflict the requester other than the last-served one wins.
  always_comb begin
    w_pick  = req1 & (~req0 | ~r_lp);
    w_wr    = w_pick ? wr1    : wr0;
    w_addr  = w_pick ? addr1  : addr0;
    w_wdata = w_pick ? wdata1 : wdata0;
    case (w_addr[31:28])
      4'h1:    w_dec = 2'b01;
      4'h2:    w_dec = 2'b10;
      default: w_dec = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_lp      <= 1'b1;
      r_owner   <= 1'b0;
      r_dec_err <= 1'b0;
      r_wait    <= '0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      psel      <= 2'b00;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req0 | req1) begin
            gnt0      <= ~w_pick;
            gnt1      <= w_pick;
            r_owner   <= w_pick;
            r_lp      <= w_pick;
            pwrite    <= w_wr;
            paddr     <= w_addr;
            pwdata    <= w_wdata;
            // A decode miss leaves psel at 00 so the bus stays quiet.
            psel      <= w_dec;
            penable   <= 1'b0;
            r_dec_err <= (w_dec == 2'b00);
            r_state   <= SETUP;
          end
        end
        SETUP: begin
          if (r_dec_err) begin
            done0   <= ~r_owner;
            done1   <= r_owner;
            err     <= 1'b1;
            r_state <= IDLE;
          end else begin
            penable <= 1'b1;
            r_wait  <= '0;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          // pready is checked first so a response on the timeout edge wins.
          if (pready) begin
            done0   <= ~r_owner;
            done1   <= r_owner;
            err     <= pslverr;
            if (!pwrite) begin
              rdata <= prdata;
            end
            psel    <= 2'b00;
            penable <= 1'b0;
            r_state <= IDLE;
          end else if (r_wait == c_wait_last) begin
            done0   <= ~r_owner;
            done1   <= r_owner;
            err     <= 1'b1;
            rdata   <= '0;
            psel    <= 2'b00;
            penable <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_wait  <= r_wait + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_arb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_arb_master
// Description : Self-checking bench for apb_arb_master. A transaction-level
//               reference model predicts grants, completion cycles and
//               results from the arbitration/decode/timing rules; directed
//               scenarios are followed by randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_arb_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, wr0, wr1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] rdata;
  logic        err;
  logic [1:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  // Requester-side stimulus, indexed by requester number.
  logic        t_req   [2];
  logic        t_wr    [2];
  logic [31:0] t_addr  [2];
  logic [31:0] t_wdata [2];

  assign req0   = t_req[0];
  assign req1   = t_req[1];
  assign wr0    = t_wr[0];
  assign wr1    = t_wr[1];
  assign addr0  = t_addr[0];
  assign addr1  = t_addr[1];
  assign wdata0 = t_wdata[0];
  assign wdata1 = t_wdata[1];

  apb_arb_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int cyc   = 0;
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, act, exp, cyc);
  endtask

  // ---------------- reference model (transaction timeline) ----------------
  bit          m_busy, m_who, m_dec_err, m_timeout, m_wr, m_lp, m_err;
  int          m_tg, m_tdone, m_wait;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [1:0]  m_dec;
  bit          reset_cyc;
  logic [1:0]  exp_gnt, exp_done;
  bit          owed [2];

  // Inputs as they stood just before the edge being modelled.
  logic        s_rst, s_pslverr;
  logic [1:0]  s_req, s_wr;
  logic [31:0] s_addr [2];
  logic [31:0] s_wdata [2];
  logic [31:0] s_prdata;

  // Stimulus control.
  bit          auto_req, keep_req, force_rd_en;
  int          force_wait, force_err;
  logic [31:0] force_rd;

  function automatic logic [1:0] region(input logic [31:0] a);
    if (a[31:28] == 4'h1) return 2'b01;
    if (a[31:28] == 4'h2) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5) return $urandom_range(0, 3);
    if (r == 6) return TO - 1;
    if (r == 7) return TO;
    if (r == 8) return TO + 2;
    return $urandom_range(4, 8);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    int r;
    a = $urandom;
    r = $urandom_range(0, 19);
    if (r < 9)       a[31:28] = 4'h1;
    else if (r < 18) a[31:28] = 4'h2;
    else if (r == 18) a[31:28] = 4'h0;
    else             a[31:28] = 4'($urandom_range(3, 15));
    return a;
  endfunction

  task automatic model_edge();
    exp_gnt   = 2'b00;
    exp_done  = 2'b00;
    reset_cyc = !s_rst;
    if (!s_rst) begin
      m_busy  = 0;
      m_lp    = 1;
      m_rdata = '0;
      m_err   = 0;
    end else if (m_busy) begin
      if (cyc == m_tdone) begin
        exp_done[m_who] = 1'b1;
        m_busy = 0;
        if (m_dec_err || m_timeout) m_err = 1;
        else m_err = s_pslverr;
        if (m_timeout) m_rdata = '0;
        else if (!m_dec_err && !m_wr) m_rdata = s_prdata;
      end
    end else if (s_req != 2'b00) begin
      m_who     = (s_req == 2'b11) ? !m_lp : s_req[1];
      m_lp      = m_who;
      m_wr      = s_wr[m_who];
      m_addr    = s_addr[m_who];
      m_wdata   = s_wdata[m_who];
      m_dec     = region(m_addr);
      m_dec_err = (m_dec == 2'b00);
      m_wait    = (force_wait >= 0) ? force_wait : pick_wait();
      m_timeout = !m_dec_err && (m_wait >= TO);
      m_tg      = cyc;
      if (m_dec_err)      m_tdone = cyc + 1;
      else if (m_timeout) m_tdone = cyc + 1 + TO;
      else                m_tdone = cyc + 2 + m_wait;
      exp_gnt[m_who] = 1'b1;
      m_busy = 1;
    end
  endtask

  task automatic check_outputs();
    logic [1:0] exp_psel;
    if (reset_cyc) begin
      chk("rst_psel", psel, 0);     chk("rst_penable", penable, 0);
      chk("rst_pwrite", pwrite, 0); chk("rst_paddr", paddr, 0);
      chk("rst_pwdata", pwdata, 0); chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);       chk("rst_gnt", {gnt1, gnt0}, 0);
      chk("rst_done", {done1, done0}, 0);
    end else begin
      chk("gnt", {gnt1, gnt0}, exp_gnt);
      chk("done", {done1, done0}, exp_done);
      exp_psel = (m_busy && !m_dec_err) ? m_dec : 2'b00;
      chk("psel", psel, exp_psel);
      chk("penable", penable, (m_busy && !m_dec_err && cyc > m_tg) ? 1 : 0);
      if (exp_psel != 2'b00) begin
        chk("paddr", paddr, m_addr);
        chk("pwdata", pwdata, m_wdata);
        chk("pwrite", pwrite, m_wr);
      end
      if (exp_done != 2'b00) begin
        chk("err", err, m_err);
        if (!m_dec_err) chk("rdata", rdata, m_rdata);
      end
    end
  endtask

  task automatic new_op(input int i);
    t_req[i]   = 1'b1;
    t_wr[i]    = 1'($urandom_range(0, 1));
    t_addr[i]  = rand_addr();
    t_wdata[i] = $urandom;
  endtask

  task automatic drive_next();
    // APB slave: pready follows the planned wait count inside ACCESS and is
    // random noise everywhere else.
    if (m_busy && !m_dec_err && cyc > m_tg) pready = ((cyc - m_tg - 1) >= m_wait);
    else pready = 1'($urandom_range(0, 1));
    if (force_err >= 0) pslverr = 1'(force_err);
    else pslverr = ($urandom_range(0, 3) == 0);
    prdata = force_rd_en ? force_rd : $urandom;
    for (int i = 0; i < 2; i++) begin
      if (reset_cyc) begin
        owed[i] = 0;
        if (auto_req) t_req[i] = 1'b0;
      end else if (exp_done[i]) begin
        owed[i] = 0;
        if (auto_req) begin
          if ($urandom_range(0, 1) == 1) new_op(i);
          else t_req[i] = 1'b0;
        end else if (!keep_req) begin
          t_req[i] = 1'b0;
        end
      end else if (exp_gnt[i]) begin
        owed[i] = 1;
        if (auto_req) begin
          // Operands and req may change once granted; the transfer must not.
          t_addr[i]  = $urandom;
          t_wdata[i] = $urandom;
          t_wr[i]    = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) t_req[i] = 1'b0;
        end
      end else if (auto_req && !owed[i] && !t_req[i] && $urandom_range(0, 2) == 0) begin
        new_op(i);
      end
    end
  endtask

  task automatic step();
    s_rst     = rst_n;
    s_req     = {t_req[1], t_req[0]};
    s_wr      = {t_wr[1], t_wr[0]};
    s_addr    = t_addr;
    s_wdata   = t_wdata;
    s_prdata  = prdata;
    s_pslverr = pslverr;
    @(posedge clk);
    #1;
    cyc++;
    model_edge();
    check_outputs();
    drive_next();
  endtask

  task automatic drain();
    t_req[0] = 1'b0;
    t_req[1] = 1'b0;
    for (int k = 0; k < 3 * TO && m_busy; k++) step();
    chk("drain_timeout", m_busy, 0);
    step();
  endtask

  // ------------------------------ stimulus ------------------------------
  int tg, td, tp, n;
  int gq[$];

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      t_req[i] = 1'b0; t_wr[i] = 1'b0; t_addr[i] = '0; t_wdata[i] = '0; owed[i] = 0;
    end
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    auto_req = 0; keep_req = 0; force_rd_en = 0; force_rd = '0;
    force_wait = -1; force_err = -1;
    m_busy = 0; m_lp = 1; m_rdata = '0; m_err = 0;

    step(); step();
    rst_n = 1'b1;
    step();

    // Zero-wait write from requester 0.
    force_wait = 0; force_err = 0;
    t_req[0] = 1'b1; t_wr[0] = 1'b1; t_addr[0] = 32'h1000_0004; t_wdata[0] = 32'hA5A5_0001;
    tg = -1; td = -1; tp = -1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (gnt0 === 1'b1 && tg < 0) tg = cyc;
      if (penable === 1'b1 && tp < 0) tp = cyc;
      if (done0 === 1'b1 && td < 0) begin td = cyc; chk("wr0_err", err, 0); end
    end
    chk("wr0_penable_delay", tp - tg, 1);
    chk("wr0_done_delay", td - tg, 2);
    drain();

    // Read from requester 1 with three wait states.
    force_wait = 3; force_rd_en = 1; force_rd = 32'hDEAD_BEEF;
    t_req[1] = 1'b1; t_wr[1] = 1'b0; t_addr[1] = 32'h2000_0000;
    n = 0; td = -1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (psel === 2'b10) n++;
      if (done1 === 1'b1 && td < 0) begin td = cyc; chk("rd1_rdata", rdata, 32'hDEAD_BEEF); end
    end
    chk("rd1_psel_cycles", n, 5);
    chk("rd1_done_seen", (td > 0) ? 1 : 0, 1);
    force_rd_en = 0;
    drain();

    // Both requesters held high: grants must alternate starting with 0.
    force_wait = 0; keep_req = 1;
    t_req[0] = 1'b1; t_wr[0] = 1'b1; t_addr[0] = 32'h1000_0010; t_wdata[0] = 32'h0000_1111;
    t_req[1] = 1'b1; t_wr[1] = 1'b1; t_addr[1] = 32'h2000_0020; t_wdata[1] = 32'h0000_2222;
    gq.delete();
    for (int k = 0; k < 24; k++) begin
      step();
      if (gnt0 === 1'b1) gq.push_back(0);
      if (gnt1 === 1'b1) gq.push_back(1);
    end
    chk("rr_grant_count", (gq.size() >= 6) ? 1 : 0, 1);
    for (int k = 0; k < gq.size(); k++) chk("rr_order", gq[k], k % 2);
    keep_req = 0;
    drain();

    // Decode miss: no bus activity, error on the cycle after grant.
    force_err = -1;
    t_req[0] = 1'b1; t_wr[0] = 1'b1; t_addr[0] = 32'h3000_0000;
    n = 0; tg = -1; td = -1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (psel !== 2'b00) n++;
      if (gnt0 === 1'b1 && tg < 0) tg = cyc;
      if (done0 === 1'b1 && td < 0) begin td = cyc; chk("dec_err_flag", err, 1); end
    end
    chk("dec_psel_active", n, 0);
    chk("dec_done_delay", td - tg, 1);
    drain();

    // pready never arrives: abort after TO ACCESS cycles.
    force_wait = TO + 5;
    t_req[0] = 1'b1; t_wr[0] = 1'b0; t_addr[0] = 32'h1000_0008;
    n = 0; tg = -1; td = -1;
    for (int k = 0; k < TO + 6; k++) begin
      step();
      if (penable === 1'b1) n++;
      if (gnt0 === 1'b1 && tg < 0) tg = cyc;
      if (done0 === 1'b1 && td < 0) begin
        td = cyc;
        chk("to_err", err, 1); chk("to_rdata", rdata, 0); chk("to_psel", psel, 0);
      end
    end
    chk("to_access_cycles", n, TO);
    chk("to_done_delay", td - tg, TO + 1);
    drain();

    // pready on the very edge that would time out: normal completion.
    force_wait = TO - 1; force_err = 0;
    t_req[1] = 1'b1; t_wr[1] = 1'b1; t_addr[1] = 32'h2000_0040; t_wdata[1] = 32'h1234_5678;
    tg = -1; td = -1;
    for (int k = 0; k < TO + 6; k++) begin
      step();
      if (gnt1 === 1'b1 && tg < 0) tg = cyc;
      if (done1 === 1'b1 && td < 0) begin td = cyc; chk("edge_err", err, 0); end
    end
    chk("edge_done_delay", td - tg, TO + 1);
    drain();

    // Reset in the middle of ACCESS after requester 0 was served.
    force_wait = TO + 5; force_err = -1;
    t_req[0] = 1'b1; t_wr[0] = 1'b1; t_addr[0] = 32'h1000_0100; t_wdata[0] = 32'hCAFE_0000;
    for (int k = 0; k < 6 && penable !== 1'b1; k++) step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    t_req[0] = 1'b1; t_req[1] = 1'b1; t_addr[1] = 32'h2000_0000;
    force_wait = 0;
    step();
    chk("post_rst_grant", {gnt1, gnt0}, 2'b01);
    for (int k = 0; k < 4; k++) step();
    drain();

    // Randomized traffic with occasional resets.
    auto_req = 1; force_wait = -1; force_err = -1;
    for (int k = 0; k < 1500; k++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n = 1'b1;
    auto_req = 0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
